seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
Parametrised multiplexed hex display driver. Latches an N-digit packed hex value, scans one digit per slot, drives shared segment/dp lines and per-digit enables with configurable polarity. Adds tear-free frame-aligned update, anti-ghosting dead time, leading-zero blanking and per-digit enable. Sits between the datapath/register file and the board's common-anode/cathode display.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..16)
CLK_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+1)
BLANK_CYCLES, 2, dead-time cycles at the start of each slot with all digit enables inactive
SEG_ACTIVE_LOW, 1, 1 = seg/dp driven low to light
AN_ACTIVE_LOW, 1, 1 = digit enable driven low to select

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
value  in  4*NUM_DIGITS  packed hex digits; digit k = value[4k+3:4k], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit
digit_en  in  NUM_DIGITS  1 = digit may light; 0 = forced blank
lz_blank  in  1  1 = enable leading-zero blanking
load  in  1  single-cycle request to capture value/dp_in/digit_en
seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
an  out  NUM_DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW
frame_done  out  1  one-cycle pulse when last digit slot ends
busy  out  1  high while a captured load awaits frame boundary

Behaviour:
- Clock is clk; reset is synchronous, active-high on rst. All outputs registered.
- Reset: prescaler=0, digit index=0, pending/display registers=0, busy=0, frame_done=0, an all inactive, seg and dp inactive (unlit).
- Prescaler counts 0..CLK_DIV-1, wraps to 0. At count CLK_DIV-1 index advances; NUM_DIGITS-1 wraps to 0, frame_done pulses that cycle.
- Slot phase: prescaler < BLANK_CYCLES -> an all inactive, seg/dp unlit; else an selects current index.
- Output latency: seg/dp/an reflect the prescaler/index state of the previous cycle (1 register stage).
- load: captures inputs into pending set and sets busy the next cycle. Pending set copies into display set on the wrap cycle (index NUM_DIGITS-1 -> 0); busy clears the same cycle. A new load while busy overwrites pending (last wins). A load coinciding with the wrap cycle is captured into pending and applied at the following wrap.
- Digit k is blank (seg unlit, dp unlit, an still selected) when digit_en[k]=0, or when lz_blank=1, k>0 and digits NUM_DIGITS-1..k of the display set are all zero. Digit 0 is never blanked by leading-zero logic.
- Non-blank digit: seg = hex decode of the 4-bit nibble (0-F incl. A,b,C,d,E,F), dp = dp_in[k]; polarity inverted when SEG_ACTIVE_LOW=1.
- rst mid-frame: everything returns to reset values next cycle; pending load discarded.
- Index width = clog2(NUM_DIGITS), min 1; NUM_DIGITS=1 keeps index at 0, frame_done pulses every slot.

Decomposition:
- Shared package seg7_pkg: active-high 16-entry hex-to-segment constant table ({g..a}: 0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F, A=7'h77, b=7'h7C, C=7'h39, d=7'h5E, E=7'h79, F=7'h71) and SEG_BLANK constant.
- One sub-module: seg7_hex_decode (combinational nibble -> active-high segments using the package table); polarity applied in seven_seg_scan.

Test Plan:
- Reset: NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=1, active-low; hold rst -> an=4'hF, seg=7'h7F, dp=1, busy=0, frame_done=0.
- Scan: load value=16'h12AF, digit_en=4'hF -> after next wrap, per slot one cycle an=4'hF then an=4'hE seg=~7'h71, 4'hD seg=~7'h77, 4'hB seg=~7'h5B, 4'h7 seg=~7'h06; frame_done every 16 cycles.
- Tear-free: load 16'h1111 mid-frame then 16'h2222 before wrap -> busy stays high, display unchanged until wrap, then all digits show 2 (~7'h5B).
- Leading-zero: lz_blank=1, value=16'h0040 -> digits 3,2 unlit, digit 1 shows 4, digit 0 shows 0; value=16'h0000 -> only digit 0 lit showing 0.
- dp/digit_en: dp_in=4'b0010, digit_en=4'b1011 -> digit 1 dp=0 (lit), digit 2 fully unlit while an=4'hB.
- Reset mid-frame with busy=1 -> next cycle reset values; pending never displayed.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-high hex glyph table ({g,f,e,d,c,b,a})
// and the all-off pattern.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry n is the glyph for nibble n (0-9, A, b, C, d, E, F).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-high segment pattern; output polarity is handled by the caller.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed N-digit hex display driver with frame-aligned updates, per-slot
// dead time, leading-zero blanking and per-digit enables.
module seven_seg_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PS_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(CLK_DIV - 1);
    localparam logic [PS_W:0]         BLANK_W  = (PS_W + 1)'(BLANK_CYCLES);
    localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : SEG_BLANK;
    localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PS_W-1:0]         presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, disp_val_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, disp_dp_q;
    logic [NUM_DIGITS-1:0]   pend_en_q, disp_en_q;
    logic                    busy_q, busy_d;
    logic                    fdone_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    slot_end, wrap, in_dead, blank;
    logic [3:0]              nib;
    logic [6:0]              glyph;
    logic [NUM_DIGITS:0]     zabove;
    logic [NUM_DIGITS-1:0]   sel;

    seg7_hex_decode u_dec (
        .nib_i (nib),
        .seg_o (glyph)
    );

    always_comb begin
        slot_end = (presc_q == PS_LAST);
        wrap     = slot_end && (idx_q == IDX_LAST);
        presc_d  = slot_end ? '0 : presc_q + 1'b1;
        idx_d    = idx_q;
        if (slot_end)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        // zabove[k]: display digits NUM_DIGITS-1..k are all zero
        zabove[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--)
            zabove[k] = zabove[k+1] && (disp_val_q[4*k +: 4] == 4'h0);

        nib     = disp_val_q[4*idx_q +: 4];
        blank   = !disp_en_q[idx_q] || (lz_blank && (idx_q != '0) && zabove[idx_q]);
        in_dead = ({1'b0, presc_q} < BLANK_W);

        sel        = '0;
        sel[idx_q] = 1'b1;

        an_d  = in_dead ? AN_OFF : (sel ^ AN_OFF);
        seg_d = (in_dead || blank) ? SEG_OFF : (glyph ^ SEG_OFF);
        dp_d  = (in_dead || blank) ? DP_OFF  : (disp_dp_q[idx_q] ^ DP_OFF);

        // A load on the wrap cycle wins over the clear: it waits for the next frame.
        busy_d = load ? 1'b1 : (wrap ? 1'b0 : busy_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_en_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            disp_en_q  <= '0;
            busy_q     <= 1'b0;
            fdone_q    <= 1'b0;
            seg_q      <= SEG_OFF;
            dp_q       <= DP_OFF;
            an_q       <= AN_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            fdone_q <= wrap;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            if (wrap && busy_q) begin
                disp_val_q <= pend_val_q;
                disp_dp_q  <= pend_dp_q;
                disp_en_q  <= pend_en_q;
            end
            if (load) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_in;
                pend_en_q  <= digit_en;
            end
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fdone_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: 4 digits, 4 cycles/slot, 1 dead cycle, active-low.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        lz_blank = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    seven_seg_scan #(
        .NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .lz_blank(lz_blank), .load(load), .seg(seg), .dp(dp), .an(an),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        value = v; dp_in = d; digit_en = e; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Returns just after the edge on which frame_done becomes visible.
    task automatic wait_frame(input string name);
        int t;
        t = 0;
        tick();
        while (frame_done !== 1'b1 && t < 40) begin
            tick();
            t++;
        end
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s: frame_done never seen, got %b want 1", name, frame_done);
        end
    endtask

    // Checks one full frame starting right after a frame_done sample.
    task automatic check_frame(input string name, input logic [3:0][6:0] exp_seg,
                               input logic [3:0] exp_dp);
        logic [3:0] exp_an;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
                n_err++;
                $display("FAIL %s dead slot %0d: an=%h seg=%h dp=%b want an=f seg=7f dp=1",
                         name, k, an, seg, dp);
            end
            if (k == 0) begin
                n_cmp++;
                if (frame_done !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s frame_done early: got %b want 0", name, frame_done);
                end
            end
            exp_an = ~(4'b0001 << k);
            for (int c = 0; c < 3; c++) begin
                tick();
                n_cmp++;
                if (an !== exp_an || seg !== exp_seg[k] || dp !== exp_dp[k]) begin
                    n_err++;
                    $display("FAIL %s digit %0d: an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                             name, k, an, seg, dp, exp_an, exp_seg[k], exp_dp[k]);
                end
            end
        end
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s frame period: frame_done=%b want 1 after 16 cycles", name, frame_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset: an=%h seg=%h dp=%b busy=%b fd=%b want f 7f 1 0 0",
                     an, seg, dp, busy, frame_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        do_load(16'h12AF, 4'h0, 4'hF);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL scan busy set: got %b want 1", busy);
        end
        wait_frame("scan sync");
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL scan busy clear: got %b want 0", busy);
        end
        check_frame("scan", {~7'h06, ~7'h5B, ~7'h77, ~7'h71}, 4'hF);
    endtask

    task automatic test_tearfree();
        // Entered right after a frame_done sample; display holds 12AF.
        do_load(16'h1111, 4'h0, 4'hF);
        tick();
        n_cmp++;
        if (an !== 4'hE || seg !== ~7'h71) begin
            n_err++;
            $display("FAIL tearfree old d0: an=%h seg=%h want e %h", an, seg, ~7'h71);
        end
        do_load(16'h2222, 4'h0, 4'hF);
        repeat (3) tick();
        n_cmp++;
        if (an !== 4'hD || seg !== ~7'h77 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL tearfree old d1: an=%h seg=%h busy=%b want d %h 1",
                     an, seg, busy, ~7'h77);
        end
        wait_frame("tearfree sync");
        check_frame("tearfree", {4{~7'h5B}}, 4'hF);
    endtask

    task automatic test_lz();
        lz_blank = 1'b1;
        do_load(16'h0040, 4'h0, 4'hF);
        wait_frame("lz sync");
        check_frame("lz 0040", {7'h7F, 7'h7F, ~7'h66, ~7'h3F}, 4'hF);
        do_load(16'h0000, 4'h0, 4'hF);
        wait_frame("lz0 sync");
        check_frame("lz 0000", {7'h7F, 7'h7F, 7'h7F, ~7'h3F}, 4'hF);
        lz_blank = 1'b0;
    endtask

    task automatic test_dp_en();
        do_load(16'h12AF, 4'b0010, 4'b1011);
        wait_frame("dp sync");
        check_frame("dp_en", {~7'h06, 7'h7F, ~7'h77, ~7'h71}, 4'b1101);
    endtask

    task automatic test_reset_mid();
        do_load(16'h8888, 4'hF, 4'hF);
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid busy: got %b want 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid state: an=%h seg=%h dp=%b busy=%b fd=%b want f 7f 1 0 0",
                     an, seg, dp, busy, frame_done);
        end
        // Display set is cleared (digit_en=0), so nothing lights and 8 never appears.
        wait_frame("rst_mid sync");
        check_frame("rst_mid", {4{7'h7F}}, 4'hF);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tearfree();
        test_lz();
        test_dp_en();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
